// File: rtl/sep32_frame_if.sv
// Bus bundle between the slot-counter/TDM source, the frame reader and sep32_frame.
// master = source/reader side, slave = capture stage.
interface sep32_frame_if #(
  parameter int DW = 10
);
  logic          cen;
  logic [4:0]    slot;
  logic [DW-1:0] din;
  logic [4:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          frame_valid;
  logic          frame_ack;
  logic [31:0]   changed;
  logic [15:0]   frame_cnt;
  logic          overrun;
  logic          sync_err;

  modport master (
    output cen, slot, din, rd_addr, frame_ack,
    input  rd_data, frame_valid, changed, frame_cnt, overrun, sync_err
  );

  modport slave (
    input  cen, slot, din, rd_addr, frame_ack,
    output rd_data, frame_valid, changed, frame_cnt, overrun, sync_err
  );
endinterface

// File: rtl/sep32_frame.sv
// Captures one 32-slot TDM frame into a double buffer and hands it to a reader
// via valid/ack, with per-slot change flags and sticky overrun/sync error bits.
//
// state | meaning
// ------+----------------------------------------------------------
// SYNC  | waiting for slot 0; samples ignored until it appears
// LOCK  | capturing; every cen sample must carry slot == exp_slot
module sep32_frame #(
  parameter int DW = 10
) (
  input logic          clk,
  input logic          rst_n,
  sep32_frame_if.slave bus
);
  typedef enum logic {S_SYNC, S_LOCK} state_t;

  state_t                   state, state_nxt;
  logic [4:0]               exp_slot, exp_slot_nxt;
  logic                     wr_en, sync_break;
  logic                     wb;
  logic [1:0][31:0][DW-1:0] mem;
  logic [31:0]              chg_acc, chg_full;
  logic                     wr_diff, frame_done, swap_ok;
  logic [DW-1:0]            rd_data_q;
  logic                     frame_valid_q, overrun_q, sync_err_q;
  logic [31:0]              changed_q;
  logic [15:0]              frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_SYNC;
      exp_slot <= '0;
    end else begin
      state    <= state_nxt;
      exp_slot <= exp_slot_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    exp_slot_nxt = exp_slot;
    wr_en        = 1'b0;
    sync_break   = 1'b0;
    if (bus.cen) begin
      case (state)
        S_SYNC: begin
          if (bus.slot == 5'd0) begin
            wr_en        = 1'b1;
            exp_slot_nxt = 5'd1;
            state_nxt    = S_LOCK;
          end
        end
        S_LOCK: begin
          if (bus.slot == exp_slot) begin
            wr_en        = 1'b1;
            exp_slot_nxt = exp_slot + 5'd1;
          end else begin
            sync_break = 1'b1;
            // a stray slot 0 is a fresh frame start, so relock immediately
            if (bus.slot == 5'd0) begin
              wr_en        = 1'b1;
              exp_slot_nxt = 5'd1;
            end else begin
              state_nxt = S_SYNC;
            end
          end
        end
        default: state_nxt = S_SYNC;
      endcase
    end
  end

  // compare against the bank the reader holds, i.e. the last delivered frame
  assign wr_diff    = (bus.din != mem[~wb][bus.slot]);
  assign chg_full   = chg_acc | (32'(wr_diff) << bus.slot);
  assign frame_done = wr_en && (bus.slot == 5'd31);
  assign swap_ok    = !frame_valid_q || bus.frame_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem           <= '0;
      wb            <= 1'b0;
      chg_acc       <= '0;
      changed_q     <= '0;
      frame_cnt_q   <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      sync_err_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      rd_data_q <= mem[~wb][bus.rd_addr];
      if (wr_en) mem[wb][bus.slot] <= bus.din;
      if (sync_break) sync_err_q <= 1'b1;

      if (frame_done)                        chg_acc <= '0;
      else if (wr_en && bus.slot == 5'd0)    chg_acc <= {31'b0, wr_diff};
      else if (wr_en)                        chg_acc <= chg_full;
      else if (sync_break)                   chg_acc <= '0;

      if (frame_done && swap_ok) begin
        wb            <= ~wb;
        changed_q     <= chg_full;
        frame_cnt_q   <= frame_cnt_q + 16'd1;
        frame_valid_q <= 1'b1;
      end else begin
        if (frame_done) overrun_q <= 1'b1;
        if (bus.frame_ack) frame_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.changed     = changed_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.overrun     = overrun_q;
  assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_sep32_frame.sv
// Directed bench for sep32_frame: frame-level vector table plus hand-written
// sync-loss, clock-enable and mid-frame reset sequences.
module tb_sep32_frame;
  localparam int DW = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sep32_frame_if #(.DW(DW)) bus ();

  sep32_frame #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          ack_before;
    bit          ack31;
    int          mod_slot;
    int          mod_val;
    logic [31:0] e_changed;
    int          e_cnt;
    bit          e_valid;
    bit          e_ovr;
    int          rd_addr;
    int          e_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_slot(input int s, input int d, input logic c, input logic ack);
    @(negedge clk);
    bus.cen       = c;
    bus.slot      = 5'(s);
    bus.din       = DW'(d);
    bus.frame_ack = ack;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.cen       = 1'b0;
    bus.frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.cen = 1'b0;
    bus.frame_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
  endtask

  task automatic check_rd(input string name, input int a, input int e);
    bus.rd_addr = 5'(a);
    @(negedge clk);
    chk(name, 32'(bus.rd_data), 32'(e));
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int s = lo; s <= hi; s++) drive_slot(s, s + 3, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.cen = 1'b0;
    bus.slot = '0;
    bus.din = '0;
    bus.rd_addr = '0;
    bus.frame_ack = 1'b0;

    //          rst ackb ack31 mslot mval  changed        cnt valid ovr rd  erd
    vecs[0] = '{1'b1, 1'b0, 1'b0, -1, 0,  32'hFFFF_FFFF, 1, 1'b1, 1'b0, 7, 10};
    vecs[1] = '{1'b0, 1'b1, 1'b0,  5, 99, 32'h0000_0020, 2, 1'b1, 1'b0, 5, 99};
    vecs[2] = '{1'b0, 1'b0, 1'b0, -1, 0,  32'h0000_0020, 2, 1'b1, 1'b1, 5, 99};
    vecs[3] = '{1'b1, 1'b0, 1'b0, -1, 0,  32'hFFFF_FFFF, 1, 1'b1, 1'b0, 7, 10};
    vecs[4] = '{1'b0, 1'b0, 1'b1,  9, 0,  32'h0000_0200, 2, 1'b1, 1'b0, 9, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, -1, 0,  32'h0000_0200, 3, 1'b1, 1'b0, 9, 12};
    vecs[6] = '{1'b0, 1'b1, 1'b0, -1, 0,  32'h0000_0000, 4, 1'b1, 1'b0, 9, 12};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_changed", bus.changed, 32'd0);
    chk("rst_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_sync_err", 32'(bus.sync_err), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rst) do_reset();
      if (vecs[v].ack_before) pulse_ack();
      for (int s = 0; s < 32; s++)
        drive_slot(s, (s == vecs[v].mod_slot) ? vecs[v].mod_val : s + 3, 1'b1,
                   (s == 31) && vecs[v].ack31);
      idle();
      chk($sformatf("v%0d_valid", v), 32'(bus.frame_valid), 32'(vecs[v].e_valid));
      chk($sformatf("v%0d_cnt", v), 32'(bus.frame_cnt), 32'(vecs[v].e_cnt));
      chk($sformatf("v%0d_changed", v), bus.changed, vecs[v].e_changed);
      chk($sformatf("v%0d_overrun", v), 32'(bus.overrun), 32'(vecs[v].e_ovr));
      chk($sformatf("v%0d_sync_err", v), 32'(bus.sync_err), 32'd0);
      check_rd($sformatf("v%0d_rd", v), vecs[v].rd_addr, vecs[v].e_rd);
    end

    // slot sequence jumps 9 -> 12: fall back to SYNC
    do_reset();
    run_range(0, 9);
    drive_slot(12, 15, 1'b1, 1'b0);
    idle();
    chk("jump_sync_err", 32'(bus.sync_err), 32'd1);
    run_range(13, 31);
    idle();
    chk("jump_no_valid", 32'(bus.frame_valid), 32'd0);
    chk("jump_no_cnt", 32'(bus.frame_cnt), 32'd0);
    run_range(0, 31);
    idle();
    chk("jump_relock_valid", 32'(bus.frame_valid), 32'd1);
    chk("jump_relock_cnt", 32'(bus.frame_cnt), 32'd1);
    chk("jump_relock_changed", bus.changed, 32'hFFFF_FFFF);

    // slot sequence restarts at 0 after 9: relock immediately
    do_reset();
    run_range(0, 9);
    drive_slot(0, 3, 1'b1, 1'b0);
    idle();
    chk("restart_sync_err", 32'(bus.sync_err), 32'd1);
    run_range(1, 31);
    idle();
    chk("restart_valid", 32'(bus.frame_valid), 32'd1);
    chk("restart_cnt", 32'(bus.frame_cnt), 32'd1);
    chk("restart_changed", bus.changed, 32'hFFFF_FFFF);

    // start mid-frame at 17 with cen toggling; cen-low samples carry junk slots
    do_reset();
    for (int s = 17; s < 32; s++) begin
      drive_slot(s, s + 3, 1'b1, 1'b0);
      drive_slot(0, 77, 1'b0, 1'b0);
    end
    idle();
    chk("cen_pre_valid", 32'(bus.frame_valid), 32'd0);
    chk("cen_pre_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("cen_pre_sync_err", 32'(bus.sync_err), 32'd0);
    for (int s = 0; s < 32; s++) begin
      drive_slot(s, s + 3, 1'b1, 1'b0);
      drive_slot((s + 5) % 32, 55, 1'b0, 1'b0);
    end
    idle();
    chk("cen_valid", 32'(bus.frame_valid), 32'd1);
    chk("cen_cnt", 32'(bus.frame_cnt), 32'd1);
    chk("cen_changed", bus.changed, 32'hFFFF_FFFF);
    chk("cen_sync_err", 32'(bus.sync_err), 32'd0);
    check_rd("cen_rd", 7, 10);

    // break sync, relock, then pull reset in the middle of the frame
    run_range(0, 5);
    drive_slot(8, 11, 1'b1, 1'b0);
    for (int s = 0; s <= 10; s++) begin
      drive_slot(s, s + 3, 1'b1, 1'b0);
      drive_slot(31, 55, 1'b0, 1'b0);
    end
    idle();
    chk("mid_sync_err_set", 32'(bus.sync_err), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("mid_rst_valid", 32'(bus.frame_valid), 32'd0);
    chk("mid_rst_changed", bus.changed, 32'd0);
    chk("mid_rst_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("mid_rst_overrun", 32'(bus.overrun), 32'd0);
    chk("mid_rst_sync_err", 32'(bus.sync_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_range(11, 31);
    idle();
    chk("post_rst_valid", 32'(bus.frame_valid), 32'd0);
    chk("post_rst_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("post_rst_sync_err", 32'(bus.sync_err), 32'd0);
    check_rd("post_rst_rd", 7, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
